// File: rtl/apple1_term_pkg.sv
// rtl/apple1_term_pkg.sv - shared types and constants for the terminal display path
package apple1_term_pkg;

    localparam int CHAR_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_RELEASE = 2'd2
    } term_state_e;

    typedef enum logic {
        REQ_KBD  = 1'b0,
        REQ_HOST = 1'b1
    } requester_e;

endpackage

// File: rtl/char_fifo.sv
// rtl/char_fifo.sv - small power-of-two character FIFO with same-edge push/pop
module char_fifo
    import apple1_term_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = CHAR_W
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot on the same edge, so a full FIFO still accepts a push then.
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // Storage array; contents are don't-care while the matching count is zero.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/display_arbiter.sv
// rtl/display_arbiter.sv - round-robin keyboard/host arbiter feeding the video terminal handshake
module display_arbiter
    import apple1_term_pkg::*;
#(
    parameter int KBD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [CHAR_W-1:0] ascii_code,
    input  logic              ascii_new,
    input  logic [CHAR_W-1:0] host_data,
    input  logic              host_valid,
    output logic              host_ready,
    output logic [CHAR_W-1:0] rd,
    output logic              da,
    input  logic              rda_n,
    output logic              kbd_overflow,
    output logic              ack_timeout
);

    localparam int          CW           = $clog2(KBD_DEPTH) + 1;
    localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);

    term_state_e       state;
    requester_e        last_grant;
    logic              rda_meta;
    logic              rda_s;
    logic [19:0]       timer;
    logic [CHAR_W-1:0] fifo_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic              grant_kbd;
    logic              grant_host;

    char_fifo #(
        .DEPTH (KBD_DEPTH),
        .WIDTH (CHAR_W)
    ) u_kbd_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (ascii_new),
        .push_data (ascii_code),
        .pop       (grant_kbd),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Keyboard wins unless the host is also asking and the keyboard was served last.
    assign grant_kbd  = (state == ST_IDLE) && !fifo_empty &&
                        (!host_valid || last_grant == REQ_HOST);
    assign grant_host = (state == ST_IDLE) && host_valid && !grant_kbd;

    // Two-flop synchronizer for the terminal's asynchronous accept line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rda_meta <= 1'b1;
            rda_s    <= 1'b1;
        end else begin
            rda_meta <= rda_n;
            rda_s    <= rda_meta;
        end
    end

    // Transfer FSM: grant and load rd together, hold until accept or timeout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            last_grant  <= REQ_HOST;
            rd          <= '0;
            da          <= 1'b0;
            host_ready  <= 1'b0;
            ack_timeout <= 1'b0;
            timer       <= '0;
        end else begin
            host_ready  <= 1'b0;
            ack_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    timer <= '0;
                    if (grant_kbd) begin
                        rd         <= fifo_data;
                        da         <= 1'b1;
                        last_grant <= REQ_KBD;
                        state      <= ST_PRESENT;
                    end else if (grant_host) begin
                        rd         <= host_data;
                        da         <= 1'b1;
                        host_ready <= 1'b1;
                        last_grant <= REQ_HOST;
                        state      <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (!rda_s) begin
                        da    <= 1'b0;
                        state <= ST_RELEASE;
                    end else if (timer == TIMEOUT_LAST) begin
                        da          <= 1'b0;
                        ack_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        timer <= timer + 20'd1;
                    end
                end
                ST_RELEASE: begin
                    if (rda_s) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Sticky drop flag: a strobe lost only when full and nothing pops on that edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kbd_overflow <= 1'b0;
        end else if (ascii_new && fifo_full && !grant_kbd) begin
            kbd_overflow <= 1'b1;
        end
    end

    // Occupancy can never exceed the configured depth.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (fifo_count <= CW'(KBD_DEPTH));
        end
    end

endmodule

// File: tb/tb_display_arbiter.sv
// tb/tb_display_arbiter.sv - self-checking bench for display_arbiter
module tb_display_arbiter;
    import apple1_term_pkg::*;

    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] ascii_code, host_data, rd;
    logic       ascii_new, host_valid, rda_n;
    logic       host_ready, da, kbd_overflow, ack_timeout;

    display_arbiter #(.KBD_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .ascii_code(ascii_code), .ascii_new(ascii_new),
        .host_data(host_data), .host_valid(host_valid), .host_ready(host_ready),
        .rd(rd), .da(da), .rda_n(rda_n), .kbd_overflow(kbd_overflow),
        .ack_timeout(ack_timeout)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: pending keyboard characters, current transfer, synchronizer history
    logic [6:0] m_q[$];
    logic       m_showing, m_waiting, m_last_host, m_s1, m_s2;
    int         m_age;
    logic [6:0] m_rd;
    logic       m_da, m_hr, m_ovf, m_ack;

    // observed DUT transfers
    logic [6:0] seen[$];
    logic       prev_da;
    int         hr_dut, ack_dut;

    // terminal / host agents
    logic term_auto, term_stall, term_rand;
    int   term_delay, term_cnt;

    typedef struct {
        logic an; logic [6:0] ac; logic hv; logic [6:0] hd; logic rn;
        logic [6:0] e_rd; logic e_da; logic e_hr; logic e_ovf; logic e_ack;
    } vec_t;
    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_showing = 0; m_waiting = 0; m_last_host = 1; m_s1 = 1; m_s2 = 1;
        m_age = 0; m_rd = 0; m_da = 0; m_hr = 0; m_ovf = 0; m_ack = 0;
        seen.delete(); prev_da = 0; hr_dut = 0; ack_dut = 0; term_cnt = 0;
    endtask

    // one rising edge of the behavioural model, using the inputs present at that edge
    task automatic model_edge();
        logic s_old;
        s_old = m_s2; m_s2 = m_s1; m_s1 = rda_n;
        m_hr = 0; m_ack = 0;
        if (!m_showing && !m_waiting) begin
            if (m_q.size() > 0 && (!host_valid || m_last_host)) begin
                m_rd = m_q.pop_front(); m_da = 1; m_showing = 1; m_age = 0; m_last_host = 0;
            end else if (host_valid) begin
                m_rd = host_data; m_hr = 1; m_da = 1; m_showing = 1; m_age = 0; m_last_host = 1;
            end
        end else if (m_showing) begin
            m_age++;
            if (!s_old) begin
                m_da = 0; m_showing = 0; m_waiting = 1;
            end else if (m_age == TMO) begin
                m_da = 0; m_ack = 1; m_showing = 0;
            end
        end else if (s_old) begin
            m_waiting = 0;
        end
        if (ascii_new) begin
            if (m_q.size() < DEPTH) m_q.push_back(ascii_code);
            else m_ovf = 1;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".rd"},  32'(rd), 32'(m_rd));
        check({tag, ".da"},  32'(da), 32'(m_da));
        check({tag, ".host_ready"}, 32'(host_ready), 32'(m_hr));
        check({tag, ".kbd_overflow"}, 32'(kbd_overflow), 32'(m_ovf));
        check({tag, ".ack_timeout"}, 32'(ack_timeout), 32'(m_ack));
    endtask

    task automatic observe();
        if (da && !prev_da) seen.push_back(rd);
        prev_da = da;
        if (host_ready) hr_dut++;
        if (ack_timeout) ack_dut++;
    endtask

    task automatic drive_terminal();
        if (!term_auto) return;
        if (m_da) begin
            if (term_cnt == 0 && term_rand) begin
                term_delay = $urandom_range(0, 6);
                term_stall = ($urandom_range(0, 7) == 0);
            end
            if (!term_stall && term_cnt >= term_delay) rda_n = 0;
            term_cnt++;
        end else begin
            rda_n = 1; term_cnt = 0;
        end
    endtask

    // one model-checked clock cycle; inputs for the edge are set by the caller
    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all(tag);
        observe();
        ascii_new = 0;
        if (m_hr) host_valid = 0;
        drive_terminal();
    endtask

    task automatic do_reset();
        reset_n = 0; ascii_new = 0; ascii_code = 0; host_valid = 0; host_data = 0; rda_n = 1;
        term_auto = 0; term_stall = 0; term_rand = 0; term_delay = 3;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset.rd", 32'(rd), 0);
        check("reset.da", 32'(da), 0);
        check("reset.host_ready", 32'(host_ready), 0);
        check("reset.kbd_overflow", 32'(kbd_overflow), 0);
        check("reset.ack_timeout", 32'(ack_timeout), 0);
        reset_n = 1;
    endtask

    task automatic push_key(input logic [6:0] c, input string tag);
        ascii_new = 1; ascii_code = c;
        cycle(tag);
    endtask

    task automatic expect_seen(input string tag, input logic [6:0] exp[$]);
        check({tag, ".count"}, 32'(seen.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < seen.size(); i++)
            check($sformatf("%s.char%0d", tag, i), 32'(seen[i]), 32'(exp[i]));
    endtask

    initial begin
        // single key then host character, terminal driven by hand
        tbl[0] = '{1, 7'h41, 0, 7'h00, 1, 7'h00, 0, 0, 0, 0};
        tbl[1] = '{0, 7'h00, 0, 7'h00, 1, 7'h41, 1, 0, 0, 0};
        tbl[2] = '{0, 7'h00, 0, 7'h00, 0, 7'h41, 1, 0, 0, 0};
        tbl[3] = '{0, 7'h00, 0, 7'h00, 0, 7'h41, 1, 0, 0, 0};
        tbl[4] = '{0, 7'h00, 0, 7'h00, 0, 7'h41, 0, 0, 0, 0};
        tbl[5] = '{0, 7'h00, 0, 7'h00, 1, 7'h41, 0, 0, 0, 0};
        tbl[6] = '{0, 7'h00, 1, 7'h0D, 1, 7'h41, 0, 0, 0, 0};
        tbl[7] = '{0, 7'h00, 1, 7'h0D, 1, 7'h41, 0, 0, 0, 0};
        tbl[8] = '{0, 7'h00, 1, 7'h0D, 1, 7'h0D, 1, 1, 0, 0};
        tbl[9] = '{0, 7'h00, 0, 7'h00, 1, 7'h0D, 1, 0, 0, 0};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            ascii_new = tbl[i].an; ascii_code = tbl[i].ac;
            host_valid = tbl[i].hv; host_data = tbl[i].hd; rda_n = tbl[i].rn;
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check($sformatf("tbl%0d.rd", i), 32'(rd), 32'(tbl[i].e_rd));
            check($sformatf("tbl%0d.da", i), 32'(da), 32'(tbl[i].e_da));
            check($sformatf("tbl%0d.host_ready", i), 32'(host_ready), 32'(tbl[i].e_hr));
            check($sformatf("tbl%0d.kbd_overflow", i), 32'(kbd_overflow), 32'(tbl[i].e_ovf));
            check($sformatf("tbl%0d.ack_timeout", i), 32'(ack_timeout), 32'(tbl[i].e_ack));
        end

        // tie: keyboard queued, host arrives at the grant edge; keyboard goes first
        do_reset();
        term_auto = 1; term_delay = 3;
        push_key(7'h42, "tie");
        host_valid = 1; host_data = 7'h0D;
        repeat (40) cycle("tie");
        expect_seen("tie", '{7'h42, 7'h0D});
        check("tie.host_ready_pulses", 32'(hr_dut), 1);

        // overflow: five strobes fit behind a stalled terminal, the sixth is dropped
        do_reset();
        term_auto = 1; term_stall = 1;
        for (int i = 0; i < 5; i++) push_key(7'(8'h31 + i), "ovf");
        check("ovf.after5", 32'(kbd_overflow), 0);
        check("ovf.first_rd", 32'(rd), 32'h31);
        push_key(7'h36, "ovf");
        check("ovf.after6", 32'(kbd_overflow), 1);
        term_stall = 0; term_delay = 2;
        repeat (100) cycle("ovf");
        expect_seen("ovf", '{7'h31, 7'h32, 7'h33, 7'h34, 7'h35});

        // timeout: da held exactly TMO cycles, then next character presented
        do_reset();
        term_auto = 1; term_stall = 1;
        push_key(7'h51, "tmo");
        push_key(7'h52, "tmo");
        begin
            int run = 0;
            int guard = 0;
            while (!da && guard < 20) begin cycle("tmo"); guard++; end
            while (da && guard < 100) begin run++; cycle("tmo"); guard++; end
            check("tmo.da_cycles", 32'(run), TMO);
        end
        repeat (30) cycle("tmo");
        check("tmo.ack_pulses", 32'(ack_dut), 2);
        expect_seen("tmo", '{7'h51, 7'h52});

        // same-edge push and pop while full: nothing lost, no overflow
        do_reset();
        term_auto = 1; term_stall = 1;
        for (int i = 0; i < 5; i++) push_key(7'(8'h61 + i), "full");
        begin
            int guard = 0;
            while (!m_ack && guard < 100) begin cycle("full"); guard++; end
            check("full.wait_timeout", 32'(m_ack), 1);
        end
        push_key(7'h66, "full");
        check("full.kbd_overflow", 32'(kbd_overflow), 0);
        term_stall = 0; term_delay = 1;
        repeat (80) cycle("full");
        expect_seen("full", '{7'h61, 7'h62, 7'h63, 7'h64, 7'h65, 7'h66});
        check("full.kbd_overflow_end", 32'(kbd_overflow), 0);

        // reset mid-transfer: da falls without a clock edge, nothing survives
        do_reset();
        term_auto = 1; term_stall = 1;
        for (int i = 0; i < 4; i++) push_key(7'(8'h71 + i), "rst");
        check("rst.da_before", 32'(da), 1);
        @(posedge clk); #2;
        reset_n = 0;
        #1;
        check("rst.da_async", 32'(da), 0);
        model_reset();
        @(negedge clk);
        reset_n = 1; term_stall = 0;
        repeat (20) cycle("rst");
        check("rst.no_output", 32'(seen.size()), 0);

        // randomized traffic against the model
        do_reset();
        term_auto = 1; term_rand = 1;
        for (int i = 0; i < 2000; i++) begin
            ascii_new = ($urandom_range(0, 5) == 0);
            ascii_code = 7'($urandom);
            if (!host_valid && $urandom_range(0, 9) == 0) begin
                host_valid = 1; host_data = 7'($urandom);
            end
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
